// File: rtl/lsu_ctrl.sv
// Load/store unit: turns one decoded memory op into a single req/ack bus transfer,
// building byte enables, lane-replicated store data and extended load data.
module lsu_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              lsu_valid_i,
  input  logic              mem_wren_i,
  input  logic [2:0]        func3_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       st_data_i,
  output logic              lsu_stall_o,
  output logic              lsu_done_o,
  output logic [31:0]       ld_data_o,
  output logic              lsu_err_o,
  output logic [1:0]        err_code_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_ack_i
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE, S_ERR} state_e;

  localparam logic [1:0] ERR_MISALIGN = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          err_code_q, err_code_d;
  logic [31:0]         ld_data_q, ld_data_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          be_q, be_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [2:0]          func3_q, func3_d;

  logic                illegal, misaligned;
  logic [3:0]          be_dec;
  logic [31:0]         wdata_dec;
  logic [31:0]         lane;
  logic [31:0]         ld_ext;

  // Request decode: legality, alignment, byte enables and store lanes.
  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    illegal   = 1'b0;
    be_dec    = 4'b0000;
    wdata_dec = st_data_i;
    if (mem_wren_i) begin
      illegal = func3_i[2] | (func3_i[1:0] == 2'b11);
    end else begin
      illegal = (func3_i[1:0] == 2'b11) | (func3_i == 3'b110);
    end
    misaligned = ((func3_i[1:0] == 2'b01) & addr_i[0]) |
                 ((func3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
    case (func3_i[1:0])
      2'b00: begin
        be_dec    = 4'b0001 << addr_i[1:0];
        wdata_dec = {4{st_data_i[7:0]}};
      end
      2'b01: begin
        be_dec    = 4'b0011 << addr_i[1:0];
        wdata_dec = {2{st_data_i[15:0]}};
      end
      2'b10:   be_dec = 4'b1111;
      default: be_dec = 4'b0000;
    endcase
  end

  // Load extraction from the lane selected by the latched byte offset.
  always_comb begin
    lane = bus_rdata_i >> {addr_q[1:0], 3'b000};
    case (func3_q)
      3'b000:  ld_ext = {{24{lane[7]}}, lane[7:0]};
      3'b100:  ld_ext = {24'h0, lane[7:0]};
      3'b001:  ld_ext = {{16{lane[15]}}, lane[15:0]};
      3'b101:  ld_ext = {16'h0, lane[15:0]};
      default: ld_ext = lane;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q      <= '0;
      err_code_q <= 2'b00;
      ld_data_q  <= 32'h0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      be_q       <= 4'b0000;
      wdata_q    <= 32'h0;
      func3_q    <= 3'b000;
    end else begin
      cnt_q      <= cnt_d;
      err_code_q <= err_code_d;
      ld_data_q  <= ld_data_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      func3_q    <= func3_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    err_code_d = err_code_q;
    ld_data_d  = ld_data_q;
    we_d       = we_q;
    addr_d     = addr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    func3_d    = func3_q;
    case (state_q)
      S_IDLE: begin
        if (lsu_valid_i) begin
          if (illegal) begin
            state_d    = S_ERR;
            err_code_d = ERR_ILLEGAL;
          end else if (misaligned) begin
            state_d    = S_ERR;
            err_code_d = ERR_MISALIGN;
          end else begin
            state_d = S_BUSY;
            cnt_d   = '0;
            we_d    = mem_wren_i;
            addr_d  = addr_i;
            be_d    = be_dec;
            wdata_d = wdata_dec;
            func3_d = func3_i;
          end
        end
      end
      S_BUSY: begin
        // An ack on the final allowed cycle still completes normally.
        if (bus_ack_i) begin
          if (!we_q) ld_data_d = ld_ext;
          state_d = S_DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d    = S_ERR;
          err_code_d = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs.
  always_comb begin
    lsu_stall_o = 1'b0;
    lsu_done_o  = 1'b0;
    lsu_err_o   = 1'b0;
    bus_req_o   = 1'b0;
    bus_we_o    = 1'b0;
    bus_addr_o  = '0;
    bus_be_o    = 4'b0000;
    bus_wdata_o = 32'h0;
    case (state_q)
      S_IDLE: lsu_stall_o = lsu_valid_i;
      S_BUSY: begin
        lsu_stall_o = 1'b1;
        bus_req_o   = 1'b1;
        bus_we_o    = we_q;
        bus_addr_o  = {addr_q[ADDR_W-1:2], 2'b00};
        bus_be_o    = be_q;
        bus_wdata_o = wdata_q;
      end
      S_DONE: lsu_done_o = 1'b1;
      default: begin
        lsu_done_o = 1'b1;
        lsu_err_o  = 1'b1;
      end
    endcase
  end

  assign ld_data_o  = ld_data_q;
  assign err_code_o = err_code_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: table of single ops plus hand-written timeout,
// ack-on-last-cycle and asynchronous reset sequences.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, we, ack;
  logic [2:0]  f3;
  logic [31:0] addr, sd, rdata;
  logic        stall, done, err, req, bwe;
  logic [1:0]  code;
  logic [31:0] ld, baddr, bwdata;
  logic [3:0]  bbe;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(16)) dut (
    .clk_i(clk), .rst_i(rst), .lsu_valid_i(valid), .mem_wren_i(we), .func3_i(f3),
    .addr_i(addr), .st_data_i(sd), .lsu_stall_o(stall), .lsu_done_o(done),
    .ld_data_o(ld), .lsu_err_o(err), .err_code_o(code), .bus_req_o(req),
    .bus_we_o(bwe), .bus_addr_o(baddr), .bus_be_o(bbe), .bus_wdata_o(bwdata),
    .bus_rdata_i(rdata), .bus_ack_i(ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] sd;
    logic [31:0] rd;
    int          dly;
    logic        err;
    logic [1:0]  code;
    logic [3:0]  be;
    logic [31:0] wd;
    logic [31:0] ld;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic run_op(input vec_t v, input string tag);
    tick();
    valid = 1'b1; we = v.we; f3 = v.f3; addr = v.addr; sd = v.sd; ack = 1'b0;
    #1;
    check({tag, " stall@accept"}, 32'(stall), 32'd1);
    check({tag, " req@accept"}, 32'(req), 32'd0);
    tick();
    valid = 1'b0;
    #1;
    if (v.err) begin
      check({tag, " err req"}, 32'(req), 32'd0);
      check({tag, " err pulse"}, 32'(err), 32'd1);
      check({tag, " err done"}, 32'(done), 32'd1);
      check({tag, " err stall"}, 32'(stall), 32'd0);
      check({tag, " err code"}, 32'(code), 32'(v.code));
      check({tag, " err ld"}, ld, v.ld);
      tick(); #1;
      check({tag, " err clears"}, 32'(err), 32'd0);
      check({tag, " code held"}, 32'(code), 32'(v.code));
    end else begin
      for (int k = 0; k <= v.dly; k++) begin
        check({tag, " busy req"}, 32'(req), 32'd1);
        check({tag, " busy stall"}, 32'(stall), 32'd1);
        check({tag, " busy done"}, 32'(done), 32'd0);
        check({tag, " bus_we"}, 32'(bwe), 32'(v.we));
        check({tag, " bus_addr"}, baddr, {v.addr[31:2], 2'b00});
        check({tag, " bus_be"}, 32'(bbe), 32'(v.be));
        if (v.we) check({tag, " bus_wdata"}, bwdata, v.wd);
        if (k == v.dly) begin
          ack = 1'b1; rdata = v.rd;
        end
        tick();
        ack = 1'b0; rdata = 32'h5A5A_A5A5;
        #1;
      end
      check({tag, " done"}, 32'(done), 32'd1);
      check({tag, " done err"}, 32'(err), 32'd0);
      check({tag, " done req"}, 32'(req), 32'd0);
      check({tag, " done stall"}, 32'(stall), 32'd0);
      check({tag, " ld_data"}, ld, v.ld);
      tick(); #1;
      check({tag, " idle done"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vec_t v;
    //           we    f3      addr        sd            rd            dly err   code   be       wd            ld
    vecs[0]  = '{1'b0, 3'b000, 32'h103,    32'h0,        32'h80FF_FF11, 0, 1'b0, 2'b00, 4'b1000, 32'h0,        32'hFFFF_FF80};
    vecs[1]  = '{1'b0, 3'b100, 32'h103,    32'h0,        32'h80FF_FF11, 0, 1'b0, 2'b00, 4'b1000, 32'h0,        32'h0000_0080};
    vecs[2]  = '{1'b1, 3'b001, 32'h22,     32'hDEAD_BEEF, 32'h0,        2, 1'b0, 2'b00, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0080};
    vecs[3]  = '{1'b0, 3'b010, 32'h41,     32'h0,        32'h0,         0, 1'b1, 2'b01, 4'b0000, 32'h0,        32'h0000_0080};
    vecs[4]  = '{1'b1, 3'b100, 32'h40,     32'h1234_5678, 32'h0,        0, 1'b1, 2'b11, 4'b0000, 32'h0,        32'h0000_0080};
    vecs[5]  = '{1'b0, 3'b001, 32'h2,      32'h0,        32'hABCD_0000, 0, 1'b0, 2'b00, 4'b1100, 32'h0,        32'hFFFF_ABCD};
    vecs[6]  = '{1'b0, 3'b010, 32'h10,     32'h0,        32'hCAFE_F00D, 1, 1'b0, 2'b00, 4'b1111, 32'h0,        32'hCAFE_F00D};
    vecs[7]  = '{1'b1, 3'b000, 32'h1,      32'h0000_00A5, 32'h0,        0, 1'b0, 2'b00, 4'b0010, 32'hA5A5_A5A5, 32'hCAFE_F00D};
    vecs[8]  = '{1'b0, 3'b001, 32'h1,      32'h0,        32'h0,         0, 1'b1, 2'b01, 4'b0000, 32'h0,        32'hCAFE_F00D};
    vecs[9]  = '{1'b0, 3'b111, 32'h3,      32'h0,        32'h0,         0, 1'b1, 2'b11, 4'b0000, 32'h0,        32'hCAFE_F00D};
    vecs[10] = '{1'b1, 3'b010, 32'h8,      32'h0123_4567, 32'h0,        0, 1'b0, 2'b00, 4'b1111, 32'h0123_4567, 32'hCAFE_F00D};
    vecs[11] = '{1'b0, 3'b101, 32'h0,      32'h0,        32'h5555_F00F, 0, 1'b0, 2'b00, 4'b0011, 32'h0,        32'h0000_F00F};

    rst = 1'b1; valid = 1'b0; we = 1'b0; f3 = 3'b000; addr = 32'h0; sd = 32'h0;
    rdata = 32'h0; ack = 1'b0;
    repeat (2) tick();
    #1;
    check("reset stall", 32'(stall), 32'd0);
    check("reset req", 32'(req), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset code", 32'(code), 32'd0);
    check("reset ld", ld, 32'd0);
    tick();
    rst = 1'b0;

    for (int i = 0; i < 12; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Timeout: no ack at all.
    tick();
    valid = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h4;
    tick();
    valid = 1'b0;
    #1;
    n = 0;
    while (req === 1'b1 && n < 40) begin
      n++;
      tick(); #1;
    end
    check("timeout req cycles", 32'(n), 32'd16);
    check("timeout err", 32'(err), 32'd1);
    check("timeout done", 32'(done), 32'd1);
    check("timeout code", 32'(code), 32'd2);
    check("timeout ld kept", ld, 32'h0000_F00F);
    tick(); #1;
    check("timeout back idle", 32'(err), 32'd0);

    // Ack on the 16th BUSY cycle completes normally.
    v = '{1'b0, 3'b010, 32'h4, 32'h0, 32'h1122_3344, 15, 1'b0, 2'b00, 4'b1111, 32'h0, 32'h1122_3344};
    run_op(v, "ack16");
    check("ack16 code held", 32'(code), 32'd2);

    // Asynchronous reset between clock edges in BUSY.
    tick();
    valid = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h44;
    tick();
    valid = 1'b0;
    #1;
    check("pre-reset req", 32'(req), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("async rst req", 32'(req), 32'd0);
    check("async rst stall", 32'(stall), 32'd0);
    check("async rst addr", baddr, 32'd0);
    check("async rst be", 32'(bbe), 32'd0);
    check("async rst ld", ld, 32'd0);
    check("async rst code", 32'(code), 32'd0);
    tick();
    rst = 1'b0;

    v = '{1'b0, 3'b101, 32'h2, 32'h0, 32'h8001_0000, 0, 1'b0, 2'b00, 4'b1100, 32'h0, 32'h0000_8001};
    run_op(v, "post-reset LHU");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
